if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 28 ++
 rtl/if_stage.sv | 114 +++++++++++
 tb/tb_if_stage.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// IF-stage bundle: IF->ID handshake, instruction-memory read port, EX redirect and error flag.
interface if_stage_if #(
   parameter int unsigned BITSIZE = 32
);
   logic               IF_ID_give_o;
   logic               ID_IF_get_i;
   logic [31:0]        IF_ID_instr_o;
   logic [BITSIZE-1:0] IF_ID_pc_o;
   logic               IF_MEM_req_o;
   logic [BITSIZE-1:0] IF_MEM_addr_o;
   logic               MEM_IF_valid_i;
   logic [31:0]        MEM_IF_rdata_i;
   logic               EX_IF_redirect_i;
   logic [BITSIZE-1:0] EX_IF_target_i;
   logic               misaligned_o;

   // Fetch-stage side
   modport master (
      output IF_ID_give_o, IF_ID_instr_o, IF_ID_pc_o, IF_MEM_req_o, IF_MEM_addr_o, misaligned_o,
      input  ID_IF_get_i, MEM_IF_valid_i, MEM_IF_rdata_i, EX_IF_redirect_i, EX_IF_target_i
   );

   // Environment side (decode, memory, execute)
   modport slave (
      input  IF_ID_give_o, IF_ID_instr_o, IF_ID_pc_o, IF_MEM_req_o, IF_MEM_addr_o, misaligned_o,
      output ID_IF_get_i, MEM_IF_valid_i, MEM_IF_rdata_i, EX_IF_redirect_i, EX_IF_target_i
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding memory read, valid/ready hand-off to ID,
// branch redirect with in-flight response squashing, sticky misaligned-target trap.
module if_stage #(
   parameter int unsigned        BITSIZE      = 32,
   parameter logic [BITSIZE-1:0] RESET_VECTOR = BITSIZE'(32'h0000_0000)
) (
   input  logic       clk,
   input  logic       reset_i,
   if_stage_if.master bus
);

   typedef enum logic [2:0] {IDLE, FETCH, DROP, GIVE, ERROR} state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [BITSIZE-1:0] r_pc;
   logic [BITSIZE-1:0] w_next_pc;
   logic               r_give;
   logic               r_req;
   logic [31:0]        r_instr;
   logic [BITSIZE-1:0] r_pc_o;
   logic               r_misaligned;
   logic               w_capture;
   logic               w_set_misaligned;
   logic               w_redir_ok;
   logic               w_redir_bad;

   assign w_redir_bad = bus.EX_IF_redirect_i & (|bus.EX_IF_target_i[1:0]);
   assign w_redir_ok  = bus.EX_IF_redirect_i & ~(|bus.EX_IF_target_i[1:0]);

   // State register
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   // Next-state, next-PC and capture decisions
   always_comb begin
      w_next_state     = r_state;
      w_next_pc        = r_pc;
      w_capture        = 1'b0;
      w_set_misaligned = 1'b0;
      case (r_state)
         IDLE: w_next_state = FETCH;
         FETCH: begin
            if (w_redir_bad) begin
               w_next_state     = ERROR;
               w_set_misaligned = 1'b1;
            end else if (w_redir_ok) begin
               // Response landing with the redirect is stale; otherwise squash it later
               w_next_pc    = bus.EX_IF_target_i;
               w_next_state = bus.MEM_IF_valid_i ? FETCH : DROP;
            end else if (bus.MEM_IF_valid_i) begin
               w_capture    = 1'b1;
               w_next_state = GIVE;
            end
         end
         DROP: begin
            if (w_redir_bad) begin
               w_next_state     = ERROR;
               w_set_misaligned = 1'b1;
            end else if (w_redir_ok) begin
               w_next_pc = bus.EX_IF_target_i;
            end else if (bus.MEM_IF_valid_i) begin
               w_next_state = FETCH;
            end
         end
         GIVE: begin
            if (w_redir_bad) begin
               w_next_state     = ERROR;
               w_set_misaligned = 1'b1;
            end else if (w_redir_ok) begin
               // Target wins over PC+4 whether or not the transfer happened
               w_next_pc    = bus.EX_IF_target_i;
               w_next_state = FETCH;
            end else if (bus.ID_IF_get_i) begin
               w_next_pc    = r_pc + BITSIZE'(4);
               w_next_state = FETCH;
            end
         end
         ERROR: w_next_state = ERROR;
         default: w_next_state = IDLE;
      endcase
   end

   // PC, registered handshake outputs, captured instruction and error flag
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_pc         <= RESET_VECTOR;
         r_give       <= 1'b0;
         r_req        <= 1'b0;
         r_instr      <= 32'h0;
         r_pc_o       <= '0;
         r_misaligned <= 1'b0;
      end else begin
         r_pc   <= w_next_pc;
         r_give <= (w_next_state == GIVE);
         r_req  <= (w_next_state == FETCH) || (w_next_state == DROP);
         if (w_capture) begin
            r_instr <= bus.MEM_IF_rdata_i;
            r_pc_o  <= r_pc;
         end
         if (w_set_misaligned) r_misaligned <= 1'b1;
      end
   end

   assign bus.IF_ID_give_o  = r_give;
   assign bus.IF_ID_instr_o = r_instr;
   assign bus.IF_ID_pc_o    = r_pc_o;
   assign bus.IF_MEM_req_o  = r_req;
   assign bus.IF_MEM_addr_o = r_pc;
   assign bus.misaligned_o  = r_misaligned;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: latency-programmable memory responder,
// scoreboard of expected IF->ID transfers, table of sequential fetches, corner sequences.
module tb_if_stage;

   localparam int unsigned BITSIZE = 32;

   typedef struct {
      int unsigned lat;
      int unsigned hold;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } xfer_t;

   logic        clk;
   logic        reset_i;
   int          n_cmp;
   int          n_fail;
   int unsigned mem_lat;
   xfer_t       sb[$];

   if_stage_if #(.BITSIZE(BITSIZE)) bus();

   if_stage #(.BITSIZE(BITSIZE), .RESET_VECTOR(32'h0000_0000)) dut (
      .clk    (clk),
      .reset_i(reset_i),
      .bus    (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return 32'h0000_0013 | (a << 8);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_give();
      int n = 0;
      while (!bus.IF_ID_give_o && n < 60) begin
         tick();
         n++;
      end
      chk("give_seen", 32'(bus.IF_ID_give_o), 32'd1);
   endtask

   task automatic push(input logic [31:0] pc);
      xfer_t x;
      x.pc    = pc;
      x.instr = mem_data(pc);
      sb.push_back(x);
   endtask

   // Memory responder: accepts a request when idle, answers mem_lat cycles later for one cycle
   initial begin
      int          cnt;
      logic        busy;
      logic [31:0] maddr;
      busy = 1'b0;
      cnt  = 0;
      maddr = 32'h0;
      bus.MEM_IF_valid_i = 1'b0;
      bus.MEM_IF_rdata_i = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.MEM_IF_valid_i) begin
            bus.MEM_IF_valid_i = 1'b0;
            busy = 1'b0;
         end
         if (busy) begin
            cnt--;
            if (cnt == 0) begin
               bus.MEM_IF_valid_i = 1'b1;
               bus.MEM_IF_rdata_i = mem_data(maddr);
            end
         end else if (bus.IF_MEM_req_o && !reset_i) begin
            busy  = 1'b1;
            cnt   = int'(mem_lat);
            maddr = bus.IF_MEM_addr_o;
         end
      end
   end

   // Transfer monitor: pops scoreboard on every give&get, checks hold-stability under backpressure
   initial begin
      logic        p_give;
      logic        p_xfer;
      logic [31:0] p_instr;
      logic [31:0] p_pc;
      xfer_t       x;
      p_give = 1'b0;
      p_xfer = 1'b0;
      p_instr = 32'h0;
      p_pc = 32'h0;
      forever begin
         @(negedge clk);
         if (reset_i) begin
            p_give = 1'b0;
            p_xfer = 1'b0;
         end else begin
            if (p_give && !p_xfer && bus.IF_ID_give_o) begin
               chk("hold_instr", bus.IF_ID_instr_o, p_instr);
               chk("hold_pc", bus.IF_ID_pc_o, p_pc);
            end
            if (bus.IF_ID_give_o && bus.ID_IF_get_i) begin
               if (sb.size() == 0) begin
                  chk("unexpected_give_pc", bus.IF_ID_pc_o, 32'hFFFF_FFFF);
               end else begin
                  x = sb.pop_front();
                  chk("xfer_pc", bus.IF_ID_pc_o, x.pc);
                  chk("xfer_instr", bus.IF_ID_instr_o, x.instr);
               end
            end
            p_give  = bus.IF_ID_give_o;
            p_xfer  = bus.IF_ID_give_o & bus.ID_IF_get_i;
            p_instr = bus.IF_ID_instr_o;
            p_pc    = bus.IF_ID_pc_o;
         end
      end
   end

   vec_t tbl[5];

   initial begin
      tbl[0] = '{lat: 1, hold: 0, exp_pc: 32'h04, exp_instr: mem_data(32'h04)};
      tbl[1] = '{lat: 3, hold: 5, exp_pc: 32'h08, exp_instr: mem_data(32'h08)};
      tbl[2] = '{lat: 2, hold: 2, exp_pc: 32'h0C, exp_instr: mem_data(32'h0C)};
      tbl[3] = '{lat: 4, hold: 0, exp_pc: 32'h10, exp_instr: mem_data(32'h10)};
      tbl[4] = '{lat: 1, hold: 1, exp_pc: 32'h14, exp_instr: mem_data(32'h14)};

      n_cmp = 0;
      n_fail = 0;
      mem_lat = 2;
      reset_i = 1'b1;
      bus.ID_IF_get_i = 1'b0;
      bus.EX_IF_redirect_i = 1'b0;
      bus.EX_IF_target_i = 32'h0;
      #1;
      chk("rst_give", 32'(bus.IF_ID_give_o), 32'd0);
      chk("rst_req", 32'(bus.IF_MEM_req_o), 32'd0);
      chk("rst_instr", bus.IF_ID_instr_o, 32'h0);
      chk("rst_pc_o", bus.IF_ID_pc_o, 32'h0);
      chk("rst_mis", 32'(bus.misaligned_o), 32'd0);
      chk("rst_addr", bus.IF_MEM_addr_o, 32'h0);
      repeat (3) tick();
      reset_i = 1'b0;

      // Basic fetch: latency 2, give one cycle after valid
      tick();
      chk("s1_req", 32'(bus.IF_MEM_req_o), 32'd1);
      chk("s1_addr", bus.IF_MEM_addr_o, 32'h0);
      tick();
      tick();
      chk("s1_give_early", 32'(bus.IF_ID_give_o), 32'd0);
      tick();
      chk("s1_give", 32'(bus.IF_ID_give_o), 32'd1);
      chk("s1_pc_o", bus.IF_ID_pc_o, 32'h0);
      chk("s1_instr", bus.IF_ID_instr_o, 32'h0000_0013);
      push(32'h0);
      bus.ID_IF_get_i = 1'b1;
      tick();
      bus.ID_IF_get_i = 1'b0;
      chk("s1_next_addr", bus.IF_MEM_addr_o, 32'h4);
      chk("s1_next_req", 32'(bus.IF_MEM_req_o), 32'd1);

      // Sequential fetches with varying latency and backpressure
      for (int i = 0; i < 5; i++) begin
         mem_lat = tbl[i].lat;
         sb.push_back('{pc: tbl[i].exp_pc, instr: tbl[i].exp_instr});
         wait_give();
         for (int k = 0; k < int'(tbl[i].hold); k++) begin
            chk("bp_give", 32'(bus.IF_ID_give_o), 32'd1);
            chk("bp_req", 32'(bus.IF_MEM_req_o), 32'd0);
            tick();
         end
         bus.ID_IF_get_i = 1'b1;
         tick();
         bus.ID_IF_get_i = 1'b0;
         chk("tbl_next_addr", bus.IF_MEM_addr_o, tbl[i].exp_pc + 32'd4);
         chk("tbl_sb_drained", 32'(sb.size()), 32'd0);
      end

      // Redirect during fetch: stale 0x18 response squashed
      mem_lat = 4;
      tick();
      bus.EX_IF_redirect_i = 1'b1;
      bus.EX_IF_target_i = 32'h100;
      tick();
      bus.EX_IF_redirect_i = 1'b0;
      mem_lat = 2;
      chk("s3_addr", bus.IF_MEM_addr_o, 32'h100);
      chk("s3_req", 32'(bus.IF_MEM_req_o), 32'd1);
      push(32'h100);
      wait_give();
      chk("s3_pc_o", bus.IF_ID_pc_o, 32'h100);
      bus.ID_IF_get_i = 1'b1;
      tick();
      bus.ID_IF_get_i = 1'b0;

      // Redirect coinciding with transfer in GIVE at pc 0x8
      bus.EX_IF_redirect_i = 1'b1;
      bus.EX_IF_target_i = 32'h8;
      tick();
      bus.EX_IF_redirect_i = 1'b0;
      push(32'h8);
      wait_give();
      bus.ID_IF_get_i = 1'b1;
      bus.EX_IF_redirect_i = 1'b1;
      bus.EX_IF_target_i = 32'h40;
      tick();
      bus.ID_IF_get_i = 1'b0;
      bus.EX_IF_redirect_i = 1'b0;
      chk("s4_addr", bus.IF_MEM_addr_o, 32'h40);
      chk("s4_req", 32'(bus.IF_MEM_req_o), 32'd1);
      chk("s4_once", 32'(sb.size()), 32'd0);
      push(32'h40);
      wait_give();
      bus.ID_IF_get_i = 1'b1;
      tick();
      bus.ID_IF_get_i = 1'b0;
      chk("s4_seq_addr", bus.IF_MEM_addr_o, 32'h44);

      // Misaligned target traps until reset; later redirects ignored
      bus.EX_IF_redirect_i = 1'b1;
      bus.EX_IF_target_i = 32'h42;
      tick();
      bus.EX_IF_redirect_i = 1'b0;
      chk("s5_mis", 32'(bus.misaligned_o), 32'd1);
      chk("s5_req", 32'(bus.IF_MEM_req_o), 32'd0);
      chk("s5_give", 32'(bus.IF_ID_give_o), 32'd0);
      for (int k = 0; k < 4; k++) begin
         bus.EX_IF_redirect_i = 1'b1;
         bus.EX_IF_target_i = 32'h80;
         bus.ID_IF_get_i = 1'b1;
         tick();
         chk("s5_mis_hold", 32'(bus.misaligned_o), 32'd1);
         chk("s5_req_hold", 32'(bus.IF_MEM_req_o), 32'd0);
         chk("s5_give_hold", 32'(bus.IF_ID_give_o), 32'd0);
      end
      bus.EX_IF_redirect_i = 1'b0;
      bus.ID_IF_get_i = 1'b0;
      chk("s5_addr_kept", bus.IF_MEM_addr_o, 32'h44);
      reset_i = 1'b1;
      #1;
      chk("s5_rst_mis", 32'(bus.misaligned_o), 32'd0);
      chk("s5_rst_addr", bus.IF_MEM_addr_o, 32'h0);
      chk("s5_rst_pc_o", bus.IF_ID_pc_o, 32'h0);
      chk("s5_rst_instr", bus.IF_ID_instr_o, 32'h0);
      repeat (5) tick();
      mem_lat = 3;
      reset_i = 1'b0;
      tick();
      chk("s6_req", 32'(bus.IF_MEM_req_o), 32'd1);
      chk("s6_addr", bus.IF_MEM_addr_o, 32'h0);

      // Asynchronous reset between edges while a read is outstanding
      tick();
      #3;
      reset_i = 1'b1;
      #1;
      chk("s6_req_drop", 32'(bus.IF_MEM_req_o), 32'd0);
      chk("s6_give_rst", 32'(bus.IF_ID_give_o), 32'd0);
      tick();
      tick();
      reset_i = 1'b0;
      tick();
      chk("s6_late_valid_give", 32'(bus.IF_ID_give_o), 32'd0);
      chk("s6_refetch_req", 32'(bus.IF_MEM_req_o), 32'd1);
      push(32'h0);
      bus.ID_IF_get_i = 1'b1;
      wait_give();
      tick();
      bus.ID_IF_get_i = 1'b0;
      tick();
      chk("final_sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
